i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (responder) for the other end of the bus driven by the team's i2c_master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, then receives bytes (write) or transmits bytes (read), with 9th-bit ACK handling.
- Drives SDA open-drain via an output-enable; the top level builds the tristate pad.

Parameters:
- ADDR, 7'h5E, target address (address byte 8'hBC write / 8'hBD read).

Ports:
- clk  in  1  system clock; must be ≥ 8× SCL frequency
- rst_n  in  1  asynchronous active-low reset
- scl_in  in  1  raw SCL from pad
- sda_in  in  1  raw SDA from pad
- sda_oe  out  1  1 = pull SDA low, 0 = release
- tx_data  in  8  byte to return on read; sampled on the tx_req cycle
- tx_req  out  1  1-clk pulse when tx_data is loaded into the shifter
- rx_data  out  8  last byte received on write
- rx_valid  out  1  1-clk pulse when rx_data updates
- busy  out  1  1 from START to STOP
- addr_match  out  1  1 from address-ACK until STOP or repeated START

Behaviour:
- Reset: sda_oe=0, tx_req=0, rx_data=8'h00, rx_valid=0, busy=0, addr_match=0, state=IDLE, bit counter=0. Reset is asynchronous, so asserting rst_n mid-transfer releases SDA immediately.
- Synchronisers: scl_in and sda_in each pass through 2 flops plus 1 history flop. Edges are found on the synchronised copies. Detection lags the pad by 3 clk.
- Bus conditions:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Neither counts as a data edge.
- Data timing: bits are sampled on SCL rise. sda_oe changes only on the clk after a detected SCL fall, never while SCL is high.
- State machine:
  - IDLE -> ADDR on START; busy=1, bit counter cleared.
  - ADDR: shift 8 bits MSB first. After the 8th rise, compare bits[7:1] to ADDR.
    - Match -> ADDR_ACK.
    - Mismatch -> IGNORE (sda_oe stays 0).
  - ADDR_ACK: at the next SCL fall, sda_oe=1 and addr_match=1. At the following fall, sda_oe=0.
    - R/W=0 -> RX.
    - R/W=1 -> TX: on that same fall pulse tx_req, load tx_data, and set sda_oe=~tx_data[7].
  - RX: shift 8 bits. On the 8th rise, rx_data<=byte and rx_valid pulses 1 clk. Go to RX_ACK (drive low for the 9th bit as in ADDR_ACK), then back to RX.
  - TX: at each SCL fall, present the next bit (sda_oe=~bit). At the fall after bit 0, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the 9th rise.
    - 0 (ACK) -> reload at the next fall via tx_req, continue TX.
    - 1 (NACK) -> IGNORE, SDA released.
  - IGNORE: wait for START or STOP with SDA released.
- Priority: STOP in any state -> IDLE; sda_oe=0, busy=0, addr_match=0. Repeated START in any state -> ADDR; sda_oe=0, addr_match=0, counter cleared. A partial byte is discarded with no rx_valid.
- Clock stretching is not supported; the target never holds SCL.
- General-call address 0x00 is not matched.

Test Plan:
- Write 0x6A to 0x5E (address byte 0xBC) -> sda_oe high for the whole 9th SCL period after the address and after the data; rx_data=8'h6A; exactly one rx_valid pulse; busy drops within 4 clk of STOP.
- Read from 0x5E (0xBD) with tx_data=8'h6D, master NACKs -> SDA bits 0,1,1,0,1,1,0,1 on SCL rises; one tx_req pulse; sda_oe=0 after the 8th bit; IGNORE until STOP.
- Read two bytes, tx_data 8'hA5 then 8'h3C, master ACK then NACK -> two tx_req pulses; bytes A5 then 3C seen on SDA; SDA released after the second byte.
- Address 0x5F (0xBE), then one data byte -> sda_oe never asserts; no rx_valid; addr_match stays 0.
- Write 0xBC, 4 data bits, then repeated START + 0xBD -> no rx_valid for the partial byte; second address ACKed; tx_req pulses.
- rst_n low during the 5th bit of a read with sda_oe=1 -> sda_oe=0 asynchronously, all outputs at reset values; the next START + 0xBC is ACKed normally.

Source files
------------

// File: rtl/i2c_slave_if.sv
`timescale 1ns/1ps
// i2c_slave_if
// Groups the I2C target's pad-side and user-side signals.
//   scl_in, sda_in : raw pad inputs (SDA is the wired-AND bus level)
//   sda_oe         : 1 = target pulls SDA low
//   tx_data/tx_req : byte to transmit on read, and its load strobe
//   rx_data/rx_valid : last byte received on write, and its update strobe
//   busy, addr_match : bus and addressing status
// The "slave" modport is the target's view; "master" is the environment's view.
interface i2c_slave_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       addr_match;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, tx_req, rx_data, rx_valid, busy, addr_match
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, tx_req, rx_data, rx_valid, busy, addr_match
    );
endinterface

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave
// I2C target with a fixed 7-bit address. SCL/SDA are oversampled on clk, START/STOP
// are detected on the synchronised copies, write bytes are received and ACKed, read
// bytes are fetched from tx_data and shifted out. SDA is driven open-drain via sda_oe.
// Ports:
//   clk   : system clock, at least 8x SCL
//   rst_n : asynchronous active-low reset
//   bus   : i2c_slave_if.slave (pads, tx/rx byte interface, status)
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h5E
) (
    input logic        clk,
    input logic        rst_n,
    i2c_slave_if.slave bus
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAddr    = 3'd1;
    localparam logic [2:0] StAddrAck = 3'd2;
    localparam logic [2:0] StRx      = 3'd3;
    localparam logic [2:0] StRxAck   = 3'd4;
    localparam logic [2:0] StTx      = 3'd5;
    localparam logic [2:0] StTxAck   = 3'd6;
    localparam logic [2:0] StIgnore  = 3'd7;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    // In the ACK states: 0 = waiting for the fall that starts the 9th bit,
    // 1 = 9th bit in progress (RX/ADDR ACK) or ACK seen (TX_ACK).
    logic       ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       tx_req_q, tx_req_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       match_q, match_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic load_tx;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high on both samples so a coincident SCL edge is never a bus condition.
    assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
    assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        sda_oe_d   = sda_oe_q;
        tx_req_d   = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        match_d    = match_q;
        load_tx    = 1'b0;

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            match_d  = 1'b0;
        end else if (start_det) begin
            state_d  = StAddr;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
            match_d  = 1'b0;
            cnt_d    = 3'd0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rw_d    = sda_s;
                            ack_d   = 1'b0;
                            state_d = (shift_q[6:0] == ADDR) ? StAddrAck : StIgnore;
                        end
                    end
                end
                StAddrAck, StRxAck: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_d    = 1'b1;
                            sda_oe_d = 1'b1;
                            match_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            if (state_q == StAddrAck && rw_q) begin
                                load_tx = 1'b1;
                            end else begin
                                state_d = StRx;
                            end
                        end
                    end
                end
                StRx: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            ack_d      = 1'b0;
                            state_d    = StRxAck;
                        end
                    end
                end
                StTx: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            ack_d    = 1'b0;
                            state_d  = StTxAck;
                        end else begin
                            cnt_d    = cnt_q + 3'd1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                StTxAck: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = StIgnore;
                        end else begin
                            ack_d = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        cnt_d   = 3'd0;
                        load_tx = 1'b1;
                    end
                end
                StIdle, StIgnore: begin
                end
                default: state_d = StIdle;
            endcase

            // MSB goes on the bus on the same fall that fetches the byte.
            if (load_tx) begin
                tx_req_d = 1'b1;
                shift_d  = bus.tx_data;
                sda_oe_d = ~bus.tx_data[7];
                state_d  = StTx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronisers reset to the idle bus level so release creates no edge.
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            sda_oe_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[0], bus.sda_in};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            sda_oe_q   <= sda_oe_d;
            tx_req_q   <= tx_req_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            match_q    <= match_d;
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.busy       = busy_q;
    assign bus.addr_match = match_q;

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// tb_i2c_slave
// Bit-banged I2C controller driving i2c_slave through its interface, with an
// open-drain SDA model and directed plus randomized transactions.
module tb_i2c_slave;

    localparam int Q = 40;  // quarter SCL period in ns (SCL = 16 clk)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;

    i2c_slave_if bus ();

    i2c_slave #(.ADDR(7'h5E)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    // Byte source for reads: entry k is returned on the k-th tx_req after set_tx.
    logic [7:0] tx_arr [4];
    int txreq_cnt = 0;
    int tx_base = 0;
    assign bus.tx_data = tx_arr[2'(txreq_cnt - tx_base)];

    int rx_cnt = 0;
    logic [7:0] rx_last = 8'h00;
    int oe_viol = 0;
    logic scl_prev = 1'b1;
    logic oe_prev = 1'b0;

    always @(posedge clk) begin
        if (bus.tx_req) txreq_cnt <= txreq_cnt + 1;
        if (bus.rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            rx_last <= bus.rx_data;
        end
        // SDA drive must never move while SCL is held high.
        if (rst_n && scl_m && scl_prev && (bus.sda_oe !== oe_prev)) oe_viol <= oe_viol + 1;
        scl_prev <= scl_m;
        oe_prev  <= bus.sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ack(input logic [7:0] addr_byte);
        return addr_byte[7:1] == 7'h5E;
    endfunction

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        tx_arr[0] = b0;
        tx_arr[1] = b1;
        tx_arr[2] = b2;
        tx_arr[3] = b3;
        tx_base   = txreq_cnt;
    endtask

    task automatic start_c();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic stop_c();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("busy_after_stop", 32'(bus.busy), 32'd0);
        check("match_after_stop", 32'(bus.addr_match), 32'd0);
        #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = bus.sda_in; #Q;
        scl_m = 1'b0; #Q;
    endtask

    // Writes a byte and runs the 9th bit; ack = target pulled SDA low,
    // oe_hold = sda_oe was high at both ends of the 9th SCL high phase.
    task automatic write_byte(input logic [7:0] b, output logic ack, output logic oe_hold);
        logic oe_a, oe_b;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #1;
        oe_a = bus.sda_oe; #(Q - 1);
        ack = ~bus.sda_in; #(Q - 1);
        oe_b = bus.sda_oe; #1;
        scl_m = 1'b0; #Q;
        oe_hold = oe_a & oe_b;
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic bit_v;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(bit_v);
            b = {b[6:0], bit_v};
        end
    endtask

    // Controller's 9th bit on a read; oe reports the target's drive mid-high.
    task automatic ack9(input logic nack, output logic oe);
        sda_m = nack; #Q;
        scl_m = 1'b1; #Q;
        oe = bus.sda_oe; #Q;
        scl_m = 1'b0; #Q;
    endtask

    logic ack, oe_hold, oe, bit_v;
    logic [7:0] got;
    logic [7:0] rbytes [4];
    logic [6:0] a7;
    logic rw, match;
    int rx0, tq0, nb;

    initial begin
        set_tx(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_tx_req", 32'(bus.tx_req), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_match", 32'(bus.addr_match), 32'd0);
        rst_n = 1'b1;
        #(4 * Q);

        // Write 0x6A to 0x5E.
        rx0 = rx_cnt; tq0 = txreq_cnt;
        start_c();
        check("w_busy", 32'(bus.busy), 32'd1);
        write_byte(8'hBC, ack, oe_hold);
        check("w_addr_ack", 32'(ack), 32'd1);
        check("w_addr_oe_hold", 32'(oe_hold), 32'd1);
        check("w_match", 32'(bus.addr_match), 32'd1);
        write_byte(8'h6A, ack, oe_hold);
        check("w_data_ack", 32'(ack), 32'd1);
        check("w_data_oe_hold", 32'(oe_hold), 32'd1);
        check("w_rx_data", 32'(bus.rx_data), 32'h6A);
        check("w_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        stop_c();
        check("w_txreq", 32'(txreq_cnt - tq0), 32'd0);

        // Read 0x6D, controller NACKs.
        set_tx(8'h6D, 8'hFF, 8'hFF, 8'hFF);
        tq0 = txreq_cnt;
        start_c();
        write_byte(8'hBD, ack, oe_hold);
        check("r1_addr_ack", 32'(ack), 32'd1);
        read_byte(got);
        check("r1_byte", 32'(got), 32'h6D);
        ack9(1'b1, oe);
        check("r1_oe_9th", 32'(oe), 32'd0);
        check("r1_txreq", 32'(txreq_cnt - tq0), 32'd1);
        read_bit(bit_v);
        check("r1_ignore_sda", 32'(bit_v), 32'd1);
        stop_c();

        // Read two bytes, ACK then NACK.
        set_tx(8'hA5, 8'h3C, 8'hFF, 8'hFF);
        tq0 = txreq_cnt;
        start_c();
        write_byte(8'hBD, ack, oe_hold);
        check("r2_addr_ack", 32'(ack), 32'd1);
        read_byte(got);
        check("r2_byte0", 32'(got), 32'hA5);
        ack9(1'b0, oe);
        read_byte(got);
        check("r2_byte1", 32'(got), 32'h3C);
        ack9(1'b1, oe);
        check("r2_oe_9th", 32'(oe), 32'd0);
        check("r2_txreq", 32'(txreq_cnt - tq0), 32'd2);
        stop_c();

        // Wrong address, then a data byte.
        rx0 = rx_cnt;
        start_c();
        write_byte(8'hBE, ack, oe_hold);
        check("na_addr_ack", 32'(ack), 32'd0);
        check("na_match", 32'(bus.addr_match), 32'd0);
        write_byte(8'h55, ack, oe_hold);
        check("na_data_ack", 32'(ack), 32'd0);
        check("na_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
        stop_c();

        // Partial write byte, then repeated START as read.
        set_tx(8'h96, 8'hFF, 8'hFF, 8'hFF);
        rx0 = rx_cnt; tq0 = txreq_cnt;
        start_c();
        write_byte(8'hBC, ack, oe_hold);
        check("sr_addr1_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) write_bit(1'(i));
        start_c();
        check("sr_match_clear", 32'(bus.addr_match), 32'd0);
        check("sr_busy", 32'(bus.busy), 32'd1);
        write_byte(8'hBD, ack, oe_hold);
        check("sr_addr2_ack", 32'(ack), 32'd1);
        read_byte(got);
        check("sr_byte", 32'(got), 32'h96);
        ack9(1'b1, oe);
        check("sr_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
        check("sr_txreq", 32'(txreq_cnt - tq0), 32'd1);
        stop_c();

        // Asynchronous reset while the target drives a 0 data bit.
        set_tx(8'hF0, 8'hFF, 8'hFF, 8'hFF);
        start_c();
        write_byte(8'hBD, ack, oe_hold);
        check("ar_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) read_bit(bit_v);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        check("ar_oe_before", 32'(bus.sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("ar_tx_req", 32'(bus.tx_req), 32'd0);
        check("ar_rx_data", 32'(bus.rx_data), 32'h00);
        check("ar_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_match", 32'(bus.addr_match), 32'd0);
        #(2 * Q);
        rst_n = 1'b1;
        #(2 * Q);
        start_c();
        write_byte(8'hBC, ack, oe_hold);
        check("ar_post_ack", 32'(ack), 32'd1);
        stop_c();

        // Randomized transactions against the address/byte model.
        for (int t = 0; t < 10; t++) begin
            a7 = ($urandom_range(0, 1) == 1) ? 7'h5E : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) rbytes[i] = 8'($urandom);
            match = exp_ack({a7, rw});
            if (rw) set_tx(rbytes[0], rbytes[1], rbytes[2], rbytes[3]);
            rx0 = rx_cnt; tq0 = txreq_cnt;
            start_c();
            write_byte({a7, rw}, ack, oe_hold);
            check("rnd_addr_ack", 32'(ack), 32'(match));
            if (!rw) begin
                for (int i = 0; i < nb; i++) begin
                    write_byte(rbytes[i], ack, oe_hold);
                    check("rnd_data_ack", 32'(ack), 32'(match));
                end
                check("rnd_rx_cnt", 32'(rx_cnt - rx0), match ? 32'(nb) : 32'd0);
                if (match) check("rnd_rx_last", 32'(rx_last), 32'(rbytes[nb - 1]));
            end else begin
                for (int i = 0; i < (match ? nb : 1); i++) begin
                    read_byte(got);
                    check("rnd_rd_byte", 32'(got), match ? 32'(rbytes[i]) : 32'hFF);
                    ack9((i == nb - 1) || !match, oe);
                end
                check("rnd_txreq", 32'(txreq_cnt - tq0), match ? 32'(nb) : 32'd0);
            end
            stop_c();
        end

        check("oe_stable_scl_high", 32'(oe_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
